// File: rtl/ps2_kbd_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_rx_if
// Description : Keyboard port between the PS/2 receiver and the mmio keyboard
//               registers. The receiver drives ready/overflow/data and the
//               CPU side drives the read_enable pop pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_kbd_rx_if;
  logic       read_enable;  // pop request, consumer samples data this cycle
  logic       ready;        // FIFO non-empty
  logic       overflow;     // sticky dropped-frame flag
  logic [7:0] data;         // FIFO head byte, 0 when empty

  // CPU / mmio side
  modport master (
    output read_enable,
    input  ready,
    input  overflow,
    input  data
  );

  // Receiver side
  modport slave (
    input  read_enable,
    output ready,
    output overflow,
    output data
  );
endinterface
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_rx
// Description : PS/2 device-to-host frame receiver with scan-code FIFO.
//               Synchronises the raw PS/2 pins, deserialises 11-bit frames
//               on PS/2 clock falling edges, validates them and buffers the
//               bytes for the mmio keyboard port. Partial frames are dropped
//               after TIMEOUT_CYCLES clk cycles without a PS/2 falling edge.
//               Optional macro PS2_PARITY_CHECK_EN: when defined, frames
//               must also carry odd parity to be accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  wire logic     clk,
  input  wire logic     rst,        // asynchronous, active-low
  input  wire logic     ps2_clk,
  input  wire logic     ps2_data,
  ps2_kbd_rx_if.slave   kbd
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // Synchroniser and edge-detect stages (idle-high bus, so reset to 1)
  logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_s3_q;
  logic ps2_dat_s1_q, ps2_dat_s2_q;

  // Frame deserialiser
  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q,   cnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [TW-1:0] tmr_q,   tmr_d;

  // FIFO
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        ovf_q,    ovf_d;

  logic w_fall;
  logic w_empty, w_full;
  logic w_odd_ones, w_frame_ok;
  logic w_push_req, w_push, w_pop, w_ovf_set;

  // Two-flop synchronisers plus a third clock stage for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps2_clk_s1_q <= 1'b1;
      ps2_clk_s2_q <= 1'b1;
      ps2_clk_s3_q <= 1'b1;
      ps2_dat_s1_q <= 1'b1;
      ps2_dat_s2_q <= 1'b1;
    end else begin
      ps2_clk_s1_q <= ps2_clk;
      ps2_clk_s2_q <= ps2_clk_s1_q;
      ps2_clk_s3_q <= ps2_clk_s2_q;
      ps2_dat_s1_q <= ps2_data;
      ps2_dat_s2_q <= ps2_dat_s1_q;
    end
  end

  assign w_fall = ps2_clk_s3_q & ~ps2_clk_s2_q;

  // Shift register layout after 10 shifts: [7:0]=d0..d7, [8]=parity, [9]=stop
  assign w_odd_ones = ^shreg_q[8:0];
`ifdef PS2_PARITY_CHECK_EN
  assign w_frame_ok = shreg_q[9] & w_odd_ones;
`else
  // Parity is captured but deliberately has no effect on acceptance
  assign w_frame_ok = shreg_q[9] & (w_odd_ones | 1'b1);
`endif

  // Frame FSM next-state: start detect, bit shifting with timeout, check
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (w_fall && !ps2_dat_s2_q) begin
          state_d = ST_SHIFT;
          cnt_d   = 4'd0;
          tmr_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (w_fall) begin
          shreg_d = {ps2_dat_s2_q, shreg_q[9:1]};
          cnt_d   = cnt_q + 4'd1;
          tmr_d   = '0;
          if (cnt_q == 4'd9) begin
            state_d = ST_CHECK;
          end
        end else if (tmr_q == C_TMO_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        tmr_d   = '0;
      end
    endcase
  end

  // Frame FSM state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      shreg_q <= 10'd0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      tmr_q   <= tmr_d;
    end
  end

  // FIFO status and push/pop arbitration; a pop frees the slot a full push needs
  assign w_empty    = (wr_ptr_q == rd_ptr_q);
  assign w_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_pop      = kbd.read_enable & ~w_empty;
  assign w_push_req = (state_q == ST_CHECK) & w_frame_ok;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;

  // Sticky overflow: setting wins over the clear from a successful pop
  always_comb begin
    ovf_d = ovf_q;
    if (w_ovf_set) begin
      ovf_d = 1'b1;
    end else if (w_pop) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO pointers and overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      ovf_q <= ovf_d;
    end
  end

  // FIFO storage; contents are never observed while empty, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shreg_q[7:0];
    end
  end

  assign kbd.ready    = ~w_empty;
  assign kbd.overflow = ovf_q;
  assign kbd.data     = w_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ps2_kbd_rx
// Description : Self-checking bench for ps2_kbd_rx. A table of single-frame
//               vectors plus directed sequences for latency, burst, overflow,
//               timeout and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;

  localparam int C_DEPTH   = 8;
  localparam int C_TMO     = 300;
  localparam int C_HALFBIT = 20;   // clk cycles per PS/2 clock phase

  logic clk = 1'b0;
  logic rst;
  logic ps2_clk;
  logic ps2_data;

  ps2_kbd_rx_if kbd_if ();

  ps2_kbd_rx #(
    .FIFO_DEPTH     (C_DEPTH),
    .TIMEOUT_CYCLES (C_TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kbd      (kbd_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] d;
    logic       par_bad;
    logic       stop;
    logic       store;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // {stop, parity, d7..d0, start}; correct parity makes the 9-bit count odd
  function automatic logic [10:0] mk(input logic [7:0] d, input logic par_bad, input logic stop);
    logic par;
    par = ~(^d);
    if (par_bad) par = ~par;
    return {stop, par, d, 1'b0};
  endfunction

  // Drive n bits; returns right after the last PS/2 clock fall
  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = fr[i];
      repeat (C_HALFBIT) @(negedge clk);
      ps2_clk = 1'b0;
      if (i != n - 1) begin
        repeat (C_HALFBIT) @(negedge clk);
        ps2_clk = 1'b1;
      end
    end
  endtask

  task automatic release_line();
    repeat (C_HALFBIT) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop);
    send_bits(mk(d, par_bad, stop), 11);
    release_line();
  endtask

  task automatic pop();
    @(negedge clk);
    kbd_if.read_enable = 1'b1;
    @(negedge clk);
    kbd_if.read_enable = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{d: 8'h1C, par_bad: 1'b0, stop: 1'b1, store: 1'b1};
    vecs[1] = '{d: 8'h00, par_bad: 1'b0, stop: 1'b1, store: 1'b1};
    vecs[2] = '{d: 8'hFF, par_bad: 1'b0, stop: 1'b1, store: 1'b1};
    vecs[3] = '{d: 8'hA5, par_bad: 1'b0, stop: 1'b1, store: 1'b1};
    vecs[4] = '{d: 8'h80, par_bad: 1'b0, stop: 1'b1, store: 1'b1};
    vecs[5] = '{d: 8'h1C, par_bad: 1'b0, stop: 1'b0, store: 1'b0};
`ifdef PS2_PARITY_CHECK_EN
    vecs[6] = '{d: 8'h1C, par_bad: 1'b1, stop: 1'b1, store: 1'b0};
`else
    vecs[6] = '{d: 8'h1C, par_bad: 1'b1, stop: 1'b1, store: 1'b1};
`endif

    rst = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    kbd_if.read_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, kbd_if.ready}, 32'd0);
    chk("reset_overflow", {31'd0, kbd_if.overflow}, 32'd0);
    chk("reset_data", {24'd0, kbd_if.data}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte with exact frame-to-ready latency
    send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
    repeat (3) @(posedge clk);
    #1;
    chk("latency_not_yet_ready", {31'd0, kbd_if.ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("latency_ready", {31'd0, kbd_if.ready}, 32'd1);
    chk("latency_data", {24'd0, kbd_if.data}, 32'h1C);
    release_line();
    pop();
    chk("single_pop_ready", {31'd0, kbd_if.ready}, 32'd0);
    chk("single_pop_data", {24'd0, kbd_if.data}, 32'd0);

    // Table of single frames
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].d, vecs[v].par_bad, vecs[v].stop);
      chk($sformatf("vec%0d_ready", v), {31'd0, kbd_if.ready}, {31'd0, vecs[v].store});
      if (vecs[v].store) begin
        chk($sformatf("vec%0d_data", v), {24'd0, kbd_if.data}, {24'd0, vecs[v].d});
        pop();
        chk($sformatf("vec%0d_pop_ready", v), {31'd0, kbd_if.ready}, 32'd0);
      end else begin
        chk($sformatf("vec%0d_data_zero", v), {24'd0, kbd_if.data}, 32'd0);
      end
    end

    // Burst without reading
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("burst_head0", {24'd0, kbd_if.data}, 32'hF0);
    pop();
    chk("burst_head1", {24'd0, kbd_if.data}, 32'h1C);
    pop();
    chk("burst_empty", {31'd0, kbd_if.ready}, 32'd0);

    // Overflow: 9th frame dropped, first pop clears the flag
    for (int k = 1; k <= 8; k++) send_frame(8'(k), 1'b0, 1'b1);
    chk("full_no_overflow", {31'd0, kbd_if.overflow}, 32'd0);
    send_frame(8'h09, 1'b0, 1'b1);
    chk("ovf_set", {31'd0, kbd_if.overflow}, 32'd1);
    chk("ovf_head", {24'd0, kbd_if.data}, 32'h01);
    pop();
    chk("ovf_cleared", {31'd0, kbd_if.overflow}, 32'd0);
    for (int k = 2; k <= 8; k++) begin
      chk($sformatf("ovf_drain%0d", k), {24'd0, kbd_if.data}, k);
      pop();
    end
    chk("ovf_drained", {31'd0, kbd_if.ready}, 32'd0);

    // Overflow avoided: pop coincides with the CHECK cycle
    for (int k = 1; k <= 8; k++) send_frame(8'(k), 1'b0, 1'b1);
    send_bits(mk(8'h09, 1'b0, 1'b1), 11);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("coinc_head", {24'd0, kbd_if.data}, 32'h01);
    kbd_if.read_enable = 1'b1;
    @(negedge clk);
    kbd_if.read_enable = 1'b0;
    chk("coinc_no_ovf", {31'd0, kbd_if.overflow}, 32'd0);
    release_line();
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("coinc_drain%0d", k), {24'd0, kbd_if.data}, k);
      pop();
    end
    chk("coinc_drained", {31'd0, kbd_if.ready}, 32'd0);
    chk("coinc_ovf_final", {31'd0, kbd_if.overflow}, 32'd0);

    // Timeout: partial frame abandoned, next full frame intact
    send_bits(mk(8'h0F, 1'b0, 1'b1), 5);
    repeat (C_HALFBIT) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (C_TMO + 20) @(negedge clk);
    chk("timeout_nothing", {31'd0, kbd_if.ready}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("timeout_next_ready", {31'd0, kbd_if.ready}, 32'd1);
    chk("timeout_next_data", {24'd0, kbd_if.data}, 32'h5A);
    pop();
    chk("timeout_only_one", {31'd0, kbd_if.ready}, 32'd0);

    // Reset mid-frame with bytes queued
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    send_bits(mk(8'h33, 1'b0, 1'b1), 5);
    chk("pre_reset_ready", {31'd0, kbd_if.ready}, 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_ready", {31'd0, kbd_if.ready}, 32'd0);
    chk("async_rst_overflow", {31'd0, kbd_if.overflow}, 32'd0);
    chk("async_rst_data", {24'd0, kbd_if.data}, 32'd0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b1);
    chk("post_rst_ready", {31'd0, kbd_if.ready}, 32'd1);
    chk("post_rst_data", {24'd0, kbd_if.data}, 32'h29);
    pop();
    chk("post_rst_empty", {31'd0, kbd_if.ready}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

Keyboard-side receiver that produces the CPU's keyboard inputs. It deserialises PS/2 device-to-host frames from the external keyboard pins and buffers the decoded scan codes in a FIFO. It presents the head byte, a ready flag and a sticky overflow flag to the mmio keyboard port, and pops one byte per `read_enable` pulse. It instantiates next to `single_cycle_cpu` at the top level. Its `ready`, `overflow`, `data` and `read_enable` connect to `kbd_ready`, `kbd_overflow`, `kbd_data` and `kbd_read_enable`.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: scan-code buffer entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles without a PS/2 falling edge before a partial frame is abandoned.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock pin; asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin; asynchronous.
- `read_enable`  in  1  pop request from mmio; consumer samples `data` in the same cycle.
- `ready`  out  1  FIFO non-empty.
- `overflow`  out  1  sticky: at least one frame was dropped because the FIFO was full.
- `data`  out  8  FIFO head byte; 0 when empty.

## Operation
- **Input synchronisers:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
- **Falling-edge detect:** a third register on `ps2_clk` detects falling edges. `fall` = previous synchronised value 1 and current value 0.
- **Frame format:** 11 bits, sampled on `fall`:
  - start bit = 0
  - d0..d7, LSB first
  - odd parity bit
  - stop bit = 1
- **FSM states:**
  - IDLE: on `fall` with sampled data 0 (start bit), go to SHIFT with bit count 0. On `fall` with data 1, stay in IDLE (glitch).
  - SHIFT: each `fall` shifts data into a 10-bit shift register and increments the count. After the 10th shift (parity and stop captured), go to CHECK.
  - CHECK: one cycle. Validate the frame, push if valid, return to IDLE.
- **Timeout:** in SHIFT, a counter resets on every `fall` and increments otherwise. On reaching `TIMEOUT_CYCLES - 1`, discard the partial frame and return to IDLE. No push, no flag change.
- **Validity:** stop bit must be 1. Parity rule is in Configuration. Invalid frames are silently dropped.
- **FIFO:**
  - Storage: `FIFO_DEPTH` × 8 with read/write pointers one bit wider than log2(`FIFO_DEPTH`). Pointers wrap naturally.
  - Full: MSBs differ and remaining bits equal. Empty: pointers equal.
- **Push:** a valid frame in CHECK when not full writes the byte.
- **Pop:** `read_enable` while `ready` advances the read pointer. `read_enable` while empty is ignored.
- **Push while full:**
  - If a pop occurs in the same cycle: both happen and `overflow` is unchanged.
  - Otherwise: the byte is dropped and `overflow` is set to 1.
- **Overflow clear:** cleared on any successful pop, unless that same cycle sets it. Set wins.
- **Outputs:** `data` is combinational from the head entry, gated to 0 when empty. `ready` = !empty.

## Timing
- **Reset values:**
  - FSM = IDLE; pointers, counters and shift register = 0; synchroniser stages = 1.
  - `ready` = 0, `overflow` = 0, `data` = 0.
- **Reset mid-frame:** the frame is lost, the FIFO is emptied, and reception resumes from the next start bit.
- **Edge-detect latency:** a `ps2_clk` pin fall is seen as `fall` 3 `clk` edges later.
- **Frame-to-ready latency:**
  - 11th `fall` → CHECK on the next edge.
  - Push at the end of CHECK.
  - `ready` = 1 and `data` valid the cycle after CHECK.
- **Pop timing:** the pop takes effect at the edge ending the `read_enable` cycle. The next byte (or `ready` = 0) is visible in the following cycle.
- **Minimum `clk`:** PS/2 clock is 10–16.7 kHz. `clk` must be ≥ 8× the PS/2 clock rate for reliable sampling.

## Configuration
- **`PS2_PARITY_CHECK_EN` defined:** a frame is valid only if d0..d7 plus the parity bit contain an odd number of ones, and stop = 1.
- **`PS2_PARITY_CHECK_EN` undefined:** the parity bit is captured but ignored. Only stop = 1 is required. All other behaviour is identical.

## Test plan
- **Single byte:** send 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1).
  - → `ready` = 1 and `data` = 0x1C the cycle after CHECK.
  - Pulse `read_enable` → `ready` = 0 and `data` = 0 next cycle.
- **Burst:** send 0xF0 (parity 1) then 0x1C without reading → pops return 0xF0 then 0x1C.
- **Overflow:** fill 8 bytes 0x01..0x08, send 0x09.
  - → `overflow` = 1, 0x09 discarded.
  - First pop returns 0x01 and clears `overflow`.
  - Repeat with a pop coinciding with CHECK → `overflow` stays 0 and 0x09 is stored.
- **Bad parity:** send 0x1C with parity bit 1.
  - With `PS2_PARITY_CHECK_EN`: `ready` stays 0.
  - Without it: 0x1C is stored.
- **Timeout:** send start bit plus 4 data bits, then idle for `TIMEOUT_CYCLES`. Then send a full 0x5A frame → only 0x5A is stored.
- **Reset mid-frame:** assert `rst` low after 5 bits with 2 bytes queued.
  - → `ready` = 0 and `overflow` = 0 immediately, without waiting for a `clk` edge.
  - A subsequent 0x29 frame is received correctly.
